icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and `mem_ctrl`. Hits return the instruction one cycle after the request is sampled. Misses issue a single word request on `mem_ctrl`'s icache port, hold it until the byte-serial fetch completes, fill the line, and forward the word. Flushes from mispredict recovery cancel delivery but never abort a memory transaction already in flight.

---
 rtl/icache.sv | 125 ++++++++++++
 tb/tb_icache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the fetch
// unit and the memory controller's byte-serial icache port.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  state, state_n;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];

  logic [INDEX_BITS-1:0]   pend_idx, pend_idx_n;
  logic [TAG_W-1:0]        pend_tag, pend_tag_n;
  logic                    cancelled, cancelled_n;
  logic                    inst_valid_n, mem_req_n, fill_we;
  logic [31:0]             inst_n, mem_addr_n;

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic                    unused_addr_lsb;

  assign req_idx         = fetch_addr[INDEX_BITS+1:2];
  assign req_tag         = fetch_addr[31:INDEX_BITS+2];
  assign hit             = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_lsb = ^fetch_addr[1:0];

  always_comb begin
    state_n      = state;
    inst_n       = inst;
    inst_valid_n = 1'b0;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    pend_idx_n   = pend_idx;
    pend_tag_n   = pend_tag;
    cancelled_n  = cancelled;
    fill_we      = 1'b0;
    case (state)
      IDLE: begin
        // inst_valid high forces a bubble so a held request is not re-accepted
        if (fetch_valid && !flush && !inst_valid) begin
          if (hit) begin
            inst_n       = data_mem[req_idx];
            inst_valid_n = 1'b1;
          end else begin
            mem_req_n   = 1'b1;
            mem_addr_n  = {fetch_addr[31:2], 2'b00};
            pend_idx_n  = req_idx;
            pend_tag_n  = req_tag;
            cancelled_n = 1'b0;
            state_n     = MISS;
          end
        end
      end
      MISS: begin
        // the fill always completes; flush only suppresses delivery
        if (mem_valid) begin
          fill_we    = 1'b1;
          mem_req_n  = 1'b0;
          mem_addr_n = 32'h0;
          if (!cancelled && !flush) begin
            inst_n       = mem_data;
            inst_valid_n = 1'b1;
          end
          state_n = IDLE;
        end else if (flush) begin
          cancelled_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cancelled  <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      valid_q    <= '0;
    end else if (rdy) begin
      state      <= state_n;
      cancelled  <= cancelled_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
      if (fill_we) valid_q[pend_idx] <= 1'b1;
    end
  end

  // storage arrays and pending-miss bookkeeping, never reset
  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      pend_idx <= pend_idx_n;
      pend_tag <= pend_tag_n;
      if (fill_we) begin
        tag_mem[pend_idx]  <= pend_tag;
        data_mem[pend_idx] <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomised and directed bench for icache against a line-level reference model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, fetch_valid, mem_valid;
  logic [31:0] fetch_addr, mem_data;
  logic        inst_valid, mem_req;
  logic [31:0] inst, mem_addr;

  int total = 0;
  int bad   = 0;

  // model: backing memory image plus which word address each cache index holds
  logic [31:0] mem_img [logic [29:0]];
  logic [29:0] cached  [int];

  icache #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .inst_valid(inst_valid), .inst(inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_word(input logic [31:0] a, output logic [31:0] w);
    if (!mem_img.exists(a[31:2])) mem_img[a[31:2]] = $urandom;
    w = mem_img[a[31:2]];
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return cached.exists(idx_of(a)) && cached[idx_of(a)] == a[31:2];
  endfunction

  task automatic start_miss(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    step();
    check("miss_req", mem_req, 1);
    check("miss_addr", mem_addr, {a[31:2], 2'b00});
  endtask

  task automatic do_fetch(input logic [31:0] a, input int delay);
    logic [31:0] w;
    bit exp_hit;
    get_word(a, w);
    exp_hit     = model_hit(a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    step();
    check("req_inst_valid", inst_valid, exp_hit);
    check("req_mem_req", mem_req, !exp_hit);
    if (exp_hit) begin
      check("hit_inst", inst, w);
      fetch_valid = 1'b0;
      step();
      check("hit_pulse_end", inst_valid, 0);
    end else begin
      check("miss_addr", mem_addr, {a[31:2], 2'b00});
      for (int i = 0; i < delay; i++) begin
        step();
        check("miss_hold_req", mem_req, 1);
        check("miss_no_inst", inst_valid, 0);
      end
      mem_valid = 1'b1;
      mem_data  = w;
      step();
      check("fill_inst_valid", inst_valid, 1);
      check("fill_inst", inst, w);
      check("fill_req_low", mem_req, 0);
      check("fill_addr_zero", mem_addr, 0);
      mem_valid   = 1'b0;
      fetch_valid = 1'b0;
      cached[idx_of(a)] = a[31:2];
      step();
      check("fill_pulse_end", inst_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] w, a;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; fetch_valid = 1'b0;
    fetch_addr = 32'h0; mem_valid = 1'b0; mem_data = 32'h0;
    mem_img[30'h104 >> 2] = 32'h00A00093;
    mem_img[30'h300 >> 2] = 32'h12345678;
    step(); step();
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    step();

    // cold miss, hit, conflict miss, re-miss of the evicted line
    do_fetch(32'h104, 2);
    do_fetch(32'h104, 0);
    do_fetch(32'h204, 1);
    do_fetch(32'h104, 3);

    // flush three cycles into a miss, response two cycles later
    start_miss(32'h300);
    step(); step();
    flush = 1'b1; fetch_valid = 1'b0;
    step();
    check("flush_req_held", mem_req, 1);
    check("flush_no_inst", inst_valid, 0);
    flush = 1'b0;
    step();
    check("flush_req_held2", mem_req, 1);
    mem_valid = 1'b1; mem_data = 32'h12345678;
    step();
    check("flush_fill_no_inst", inst_valid, 0);
    check("flush_fill_req_low", mem_req, 0);
    mem_valid = 1'b0;
    cached[idx_of(32'h300)] = 30'h300 >> 2;
    step();
    check("flush_still_no_inst", inst_valid, 0);
    do_fetch(32'h300, 0);

    // rdy stall with mem_valid held across it
    get_word(32'h408, w);
    start_miss(32'h408);
    rdy = 1'b0; mem_valid = 1'b1; mem_data = w;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, 32'h408);
      check("stall_no_inst", inst_valid, 0);
    end
    rdy = 1'b1;
    step();
    check("stall_inst_valid", inst_valid, 1);
    check("stall_inst", inst, w);
    check("stall_req_low", mem_req, 0);
    fetch_valid = 1'b0;
    step();
    check("stall_once_inst", inst_valid, 0);
    check("stall_once_req", mem_req, 0);
    mem_valid = 1'b0;
    cached[idx_of(32'h408)] = 30'h408 >> 2;
    do_fetch(32'h408, 0);

    // flush coinciding with the response
    get_word(32'h50C, w);
    start_miss(32'h50C);
    step();
    flush = 1'b1; mem_valid = 1'b1; mem_data = w; fetch_valid = 1'b0;
    step();
    check("flushresp_no_inst", inst_valid, 0);
    check("flushresp_req_low", mem_req, 0);
    flush = 1'b0; mem_valid = 1'b0;
    cached[idx_of(32'h50C)] = 30'h50C >> 2;
    do_fetch(32'h50C, 0);

    // flush beats a simultaneous request in IDLE
    fetch_valid = 1'b1; fetch_addr = 32'h60; flush = 1'b1;
    step();
    check("idleflush_req", mem_req, 0);
    check("idleflush_inst", inst_valid, 0);
    flush = 1'b0;
    do_fetch(32'h60, 1);

    // random traffic over a small address pool to mix hits, misses and aliasing
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 31);
      do_fetch(a, $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) step();
    end

    // reset in the middle of a miss drops the request and invalidates every line
    do_fetch(32'h104, 1);
    start_miss(32'hF00);
    step();
    rst = 1'b1; fetch_valid = 1'b0;
    step();
    check("rstmiss_req", mem_req, 0);
    check("rstmiss_inst_valid", inst_valid, 0);
    rst = 1'b0;
    cached.delete();
    do_fetch(32'h104, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
